// File: rtl/parking_pkg.sv
// rtl/parking_pkg.sv - shared parking-lot constants and sensor channel status type
package parking_pkg;

   localparam int LOT_CAPACITY            = 16;
   localparam int DEBOUNCE_CYCLES_DEFAULT = 16;
   localparam int STUCK_CYCLES_DEFAULT    = 2**20;

   // Registered view of one conditioned photo-sensor channel
   typedef struct packed {
      logic clean;
      logic rise;
      logic fall;
      logic fault;
   } chan_status_t;

endpackage

// File: rtl/debounce_channel.sv
// rtl/debounce_channel.sv - synchronizer, debouncer, edge strobes and stuck detector for one sensor
module debounce_channel
   import parking_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
   parameter int STUCK_CYCLES    = STUCK_CYCLES_DEFAULT
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         raw,
   output chan_status_t status
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES);
   localparam int SW = $clog2(STUCK_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST  = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [SW-1:0] STUCK_MAX = SW'(STUCK_CYCLES);

   logic          s1;
   logic          s2;
   logic [CW-1:0] cnt;
   logic          clean;
   logic          rise;
   logic          fall;
   logic          fault;
   logic [SW-1:0] stuck;

   logic          accept;
   logic          clean_next;
   logic [SW-1:0] stuck_next;

   // Acceptance happens on the edge where the disagreeing level has been seen for the full window;
   // the stuck count follows the current clean level and saturates at its limit
   always_comb begin
      accept     = 1'b0;
      clean_next = clean;
      stuck_next = '0;
      if ((s2 != clean) && (cnt == CNT_LAST)) begin
         accept     = 1'b1;
         clean_next = s2;
      end
      if (clean) begin
         stuck_next = (stuck == STUCK_MAX) ? stuck : stuck + SW'(1);
      end
   end

   // Two-flop synchronizer for the asynchronous GPIO level
   always_ff @(posedge clock) begin
      if (reset) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
      end else begin
         s1 <= raw;
         s2 <= s1;
      end
   end

   // Stability counter, clean level and single-cycle edge strobes
   always_ff @(posedge clock) begin
      if (reset) begin
         cnt   <= '0;
         clean <= 1'b0;
         rise  <= 1'b0;
         fall  <= 1'b0;
      end else begin
         if (s2 == clean || accept) begin
            cnt <= '0;
         end else begin
            cnt <= cnt + CW'(1);
         end
         clean <= clean_next;
         rise  <= accept & s2;
         fall  <= accept & ~s2;
      end
   end

   // Stuck-high counter; the flag drops on the very edge the clean level falls
   always_ff @(posedge clock) begin
      if (reset) begin
         stuck <= '0;
         fault <= 1'b0;
      end else begin
         stuck <= stuck_next;
         fault <= clean_next && (stuck_next == STUCK_MAX);
      end
   end

   assign status = '{clean: clean, rise: rise, fall: fall, fault: fault};

endmodule

// File: rtl/sensor_conditioner.sv
// rtl/sensor_conditioner.sv - conditions the outer (a) and inner (b) photo-sensors for the parking-lot FSM
module sensor_conditioner
   import parking_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
   parameter int STUCK_CYCLES    = STUCK_CYCLES_DEFAULT
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       a_raw,
   input  logic       b_raw,
   output logic       a_clean,
   output logic       b_clean,
   output logic       a_rise,
   output logic       a_fall,
   output logic       b_rise,
   output logic       b_fall,
   output logic [1:0] fault
);

   chan_status_t a_st;
   chan_status_t b_st;

   debounce_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .STUCK_CYCLES    (STUCK_CYCLES)
   ) u_chan_a (
      .clock  (clock),
      .reset  (reset),
      .raw    (a_raw),
      .status (a_st)
   );

   debounce_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .STUCK_CYCLES    (STUCK_CYCLES)
   ) u_chan_b (
      .clock  (clock),
      .reset  (reset),
      .raw    (b_raw),
      .status (b_st)
   );

   assign a_clean = a_st.clean;
   assign a_rise  = a_st.rise;
   assign a_fall  = a_st.fall;
   assign b_clean = b_st.clean;
   assign b_rise  = b_st.rise;
   assign b_fall  = b_st.fall;
   assign fault   = {b_st.fault, a_st.fault};

endmodule

// File: tb/tb_sensor_conditioner.sv
// tb/tb_sensor_conditioner.sv - self-checking bench for sensor_conditioner
module tb_sensor_conditioner;

   localparam int D = 4;
   localparam int S = 8;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       a_raw = 1'b0;
   logic       b_raw = 1'b0;
   logic       a_clean, b_clean, a_rise, a_fall, b_rise, b_fall;
   logic [1:0] fault;

   int n_cmp = 0;
   int n_bad = 0;

   sensor_conditioner #(
      .DEBOUNCE_CYCLES (D),
      .STUCK_CYCLES    (S)
   ) dut (
      .clock   (clock),
      .reset   (reset),
      .a_raw   (a_raw),
      .b_raw   (b_raw),
      .a_clean (a_clean),
      .b_clean (b_clean),
      .a_rise  (a_rise),
      .a_fall  (a_fall),
      .b_rise  (b_rise),
      .b_fall  (b_fall),
      .fault   (fault)
   );

   always #5 clock = ~clock;

   // reference model state: sample history (bit i = sample i edges ago), clean level, high-run length
   logic [D+1:0] ha = '0, hb = '0;
   logic         mca = 1'b0, mcb = 1'b0;
   int           run_a = 0, run_b = 0;
   logic [7:0]   sb_q[$];

   typedef struct {
      string       name;
      logic [31:0] a_pat;
      logic [31:0] b_pat;
      int          len;
      int          a_r, a_f, b_r, b_f;
      logic [1:0]  fseen;
   } vec_t;
   vec_t vecs[8];

   task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp_v);
      n_cmp++;
      if (got !== exp_v) begin
         n_bad++;
         $display("FAIL %s got=%0h expected=%0h at %0t", nm, got, exp_v, $time);
      end
   endtask

   task automatic chan_model(input logic raw, input logic r, inout logic [D+1:0] h,
                             inout logic c, inout int run,
                             output logic rs, output logic fl, output logic ft);
      logic chg;
      if (r) begin
         h = '0; c = 1'b0; run = 0; rs = 1'b0; fl = 1'b0; ft = 1'b0;
      end else begin
         h   = {h[D:0], raw};
         chg = c ? (h[D+1:2] == '0) : (h[D+1:2] == '1);
         rs  = chg & ~c;
         fl  = chg & c;
         if (chg) c = ~c;
         run = c ? ((run < 1000) ? run + 1 : run) : 0;
         ft  = (run >= S + 1);
      end
   endtask

   function automatic logic [7:0] dut_vec();
      return {a_clean, b_clean, a_rise, a_fall, b_rise, b_fall, fault};
   endfunction

   task automatic step(input logic a, input logic b, input logic r);
      logic ra, fa, ta, rb, fb, tb;
      logic [7:0] exp_v;
      a_raw = a; b_raw = b; reset = r;
      @(posedge clock);
      chan_model(a, r, ha, mca, run_a, ra, fa, ta);
      chan_model(b, r, hb, mcb, run_b, rb, fb, tb);
      sb_q.push_back({mca, mcb, ra, fa, rb, fb, tb, ta});
      @(negedge clock);
      if (sb_q.size() == 0) begin
         n_cmp++; n_bad++;
         $display("FAIL scoreboard_empty got=%0h expected=entry", dut_vec());
      end else begin
         exp_v = sb_q.pop_front();
         check("model_cycle", 32'(dut_vec()), 32'(exp_v));
      end
   endtask

   initial begin
      int ar, af, br, bf;
      logic [1:0] fs;
      logic [6:0] bounce;

      vecs[0] = '{"quiet",        32'h0,     32'h0,    10, 0, 0, 0, 0, 2'b00};
      vecs[1] = '{"a_rise_fall",  32'hFF,    32'h0,     8, 1, 1, 0, 0, 2'b00};
      vecs[2] = '{"b_glitch3",    32'h0,     32'h7,     3, 0, 0, 0, 0, 2'b00};
      vecs[3] = '{"b_bounce",     32'h0,     32'h7B,    7, 0, 0, 1, 1, 2'b00};
      vecs[4] = '{"both_rise",    32'h3F,    32'h3F,    6, 1, 1, 1, 1, 2'b00};
      vecs[5] = '{"a_exact4",     32'hF,     32'h0,     4, 1, 1, 0, 0, 2'b00};
      vecs[6] = '{"a_low_glitch", 32'h3F3FF, 32'h0,    18, 1, 1, 0, 0, 2'b01};
      vecs[7] = '{"b_two_pulses", 32'h0,     32'h7C1F, 15, 0, 0, 2, 2, 2'b00};

      // reset behaviour: outputs stay 0 through reset and ten idle cycles
      for (int i = 0; i < 12; i++) begin
         step(1'b0, 1'b0, i < 2);
         check("reset_idle_zero", 32'(dut_vec()), 32'h0);
      end

      // clean rise on a with exact latency, then held high into the stuck fault
      step(1'b0, 1'b0, 1'b1); step(1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 16; i++) begin
         step(1'b1, 1'b0, 1'b0);
         check("a_clean_latency", 32'(a_clean), 32'(i >= 5));
         check("a_rise_single",   32'(a_rise),  32'(i == 5));
         check("fault0_onset",    32'(fault[0]), 32'(i >= 13));
      end
      // release a: fault must drop on the same edge as a_clean falls
      for (int i = 0; i < 7; i++) begin
         step(1'b0, 1'b0, 1'b0);
         check("a_clean_fall",  32'(a_clean),  32'(i < 5));
         check("a_fall_single", 32'(a_fall),   32'(i == 5));
         check("fault0_clear",  32'(fault[0]), 32'(i < 5));
      end

      // b glitch of three samples is rejected
      step(1'b0, 1'b0, 1'b1); step(1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 10; i++) begin
         step(1'b0, i < 3, 1'b0);
         check("b_glitch_reject", 32'({b_clean, b_rise, b_fall}), 32'h0);
      end

      // b bounce 1,1,0,1,1,1,1 then held: window restarts at the last 0->1 sample
      step(1'b0, 1'b0, 1'b1); step(1'b0, 1'b0, 1'b1);
      bounce = 7'h7B;
      for (int i = 0; i < 11; i++) begin
         step(1'b0, (i < 7) ? bounce[i] : 1'b1, 1'b0);
         check("b_bounce_clean", 32'(b_clean), 32'(i >= 8));
         check("b_bounce_rise",  32'(b_rise),  32'(i == 8));
      end

      // simultaneous rise on both channels
      step(1'b0, 1'b0, 1'b1); step(1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 7; i++) begin
         step(1'b1, 1'b1, 1'b0);
         check("simul_rise", 32'({a_rise, b_rise}), (i == 5) ? 32'h3 : 32'h0);
      end

      // reset two edges into an a qualification, a held high across it
      step(1'b0, 1'b0, 1'b1); step(1'b0, 1'b0, 1'b1);
      step(1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b1);
      check("midreset_no_strobe", 32'({a_clean, a_rise}), 32'h0);
      for (int i = 0; i < 8; i++) begin
         step(1'b1, 1'b0, 1'b0);
         check("midreset_rise",  32'(a_rise),  32'(i == 5));
         check("midreset_clean", 32'(a_clean), 32'(i >= 5));
      end

      // table-driven vectors: strobe counts and fault visibility per pattern
      for (int v = 0; v < 8; v++) begin
         step(1'b0, 1'b0, 1'b1); step(1'b0, 1'b0, 1'b1);
         ar = 0; af = 0; br = 0; bf = 0; fs = 2'b00;
         for (int c = 0; c < vecs[v].len + 14; c++) begin
            step((c < vecs[v].len) ? vecs[v].a_pat[c] : 1'b0,
                 (c < vecs[v].len) ? vecs[v].b_pat[c] : 1'b0, 1'b0);
            ar += int'(a_rise); af += int'(a_fall);
            br += int'(b_rise); bf += int'(b_fall);
            fs |= fault;
            if (a_rise && a_fall) check({vecs[v].name, "_a_both"}, 32'h1, 32'h0);
            if (b_rise && b_fall) check({vecs[v].name, "_b_both"}, 32'h1, 32'h0);
         end
         check({vecs[v].name, "_a_rise"}, 32'(ar), 32'(vecs[v].a_r));
         check({vecs[v].name, "_a_fall"}, 32'(af), 32'(vecs[v].a_f));
         check({vecs[v].name, "_b_rise"}, 32'(br), 32'(vecs[v].b_r));
         check({vecs[v].name, "_b_fall"}, 32'(bf), 32'(vecs[v].b_f));
         check({vecs[v].name, "_fault"},  32'(fs), 32'(vecs[v].fseen));
      end

      check("scoreboard_drained", 32'(sb_q.size()), 32'h0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/sensor_conditioner.md
SENSOR_CONDITIONER -- requirements
Module: sensor_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 16, is the number of consecutive synchronized samples a new sensor level must hold before it is accepted; the legal range is 2..65535.
REQ-002 Parameter STUCK_CYCLES, default 2**20, is the number of consecutive cycles a debounced sensor may read 1 before it is flagged as stuck; the legal range is 2..2**24.
REQ-003 clock  input  1  Single system clock; every flop is updated on its rising edge.
REQ-004 reset  input  1  Synchronous, active-high reset.
REQ-005 a_raw  input  1  Asynchronous outer photo-sensor level, taken from the GPIO pin.
REQ-006 b_raw  input  1  Asynchronous inner photo-sensor level, taken from the GPIO pin.
REQ-007 a_clean, b_clean  output  1 each  Debounced levels, fed directly to the parking-lot FSM a/b inputs.
REQ-008 a_rise, a_fall, b_rise, b_fall  output  1 each  Single-cycle edge strobes of the clean levels.
REQ-009 fault  output  2  Stuck-sensor flags: bit0 is for a, bit1 is for b.

Function
REQ-010 Each raw input SHALL pass through a two-flop synchronizer (s1, s2) before any other logic uses it.
REQ-011 Each channel SHALL hold a counter cnt of width $clog2(DEBOUNCE_CYCLES), updated on every edge as follows:
- if s2 equals clean, cnt <= 0;
- else if cnt equals DEBOUNCE_CYCLES-1, clean <= s2 and cnt <= 0;
- else cnt <= cnt+1.
REQ-012 A raw level held for DEBOUNCE_CYCLES or more sampling edges SHALL be accepted; clean SHALL change on the (DEBOUNCE_CYCLES+2)th rising edge counted from the first edge that samples the new level.
REQ-013 A raw excursion held for fewer than DEBOUNCE_CYCLES sampling edges SHALL be rejected: clean does not change and no strobe fires.
REQ-014 Bounce that returns s2 to the clean level SHALL clear cnt to 0, so the stability window restarts.
REQ-015 The rise strobe SHALL be registered on the same edge at which clean goes 0->1, and SHALL be high for exactly the first cycle in which clean reads 1.
REQ-016 The fall strobe SHALL behave like the rise strobe, for clean going 1->0.
REQ-017 Rise and fall on one channel SHALL never be high in the same cycle.
REQ-018 Channels a and b SHALL operate fully independently; simultaneous transitions on both SHALL yield strobes in the same cycle with no priority between them.
REQ-019 Each channel SHALL have a stuck counter with the following behaviour:
- it increments while clean is 1 and saturates at STUCK_CYCLES;
- it clears to 0 on any cycle in which clean is 0.
REQ-020 The channel's fault bit SHALL be 1 exactly while its stuck counter equals STUCK_CYCLES.
REQ-021 A fault bit SHALL clear on the same edge at which clean falls.
REQ-022 fault SHALL NOT gate clean or the strobes; the outputs continue to reflect the sensor.
REQ-023 All outputs SHALL be driven directly from flops, with no combinational path from raw to output.

Reset
REQ-024 While reset is 1 at a rising edge, the following SHALL be forced to 0 at that edge: s1, s2, cnt, the stuck counters, the clean levels, the strobes and fault.
REQ-025 Reset SHALL discard any debounce in progress.
REQ-026 If a raw input is 1 when reset releases, the channel SHALL re-qualify it under REQ-012, timed from the first post-reset edge, and then emit a rise strobe.

Structure
REQ-027 The default debounce and stuck constants SHALL live in the shared parking_pkg package, beside the FSM's capacity constant.
REQ-028 The per-channel logic SHALL be one sub-module, debounce_channel, which contains the synchronizer, debounce counter, strobes and stuck counter.
REQ-029 sensor_conditioner SHALL instantiate debounce_channel twice and concatenate the two fault bits.

Verification (DEBOUNCE_CYCLES=4, STUCK_CYCLES=8)
REQ-030 Reset test: hold reset for 2 cycles with a_raw=b_raw=0, then release and hold 10 cycles -> every output reads 0 throughout.
REQ-031 Clean rise test: a_raw 0->1 first sampled at edge k and held -> a_clean=1 after edge k+5, and a_rise=1 for that single cycle only.
REQ-032 Glitch and bounce tests, each on b:
- b_raw high for 3 edges then low -> b_clean stays 0 and no strobe fires;
- b_raw pattern 1,1,0,1,1,1,1 -> b_clean rises 6 edges after the final 0->1 sample.
REQ-033 Simultaneous and stuck tests:
- a_raw and b_raw rise on the same edge -> a_rise and b_rise fire in the same cycle;
- with a held high, fault[0]=1 starting 8 cycles after a_clean rises, and fault[0]=0 on the cycle a_clean falls.
REQ-034 Reset-mid-debounce test: assert reset 2 edges into an a qualification -> no strobe; after release with a_raw still 1, a_rise fires 6 edges after the first post-reset edge.
